pc_sequencer: RTL and testbench
===============================

Name: pc_sequencer

Overview:
- Parametrised program-counter sequencer for the multi-cycle CPU.
- Adds two things to the branch/stack PC update:
  - a hardware return-address stack (RAS) for CALL/RET;
  - a stall enable, plus a memory-fallback handshake used when RET finds the RAS empty.
- Sits between the decode/ALU stage (which supplies branch/stack opcodes, target and condition register) and the instruction-fetch stage (which consumes pc_out).

Parameters:
- ADDR_W, 32: width of PC, target and return addresses.
- DATA_W, 32: width of signed condition operand.
- RAS_DEPTH, 8: return-address stack entries; must be a power of 2, ≥2.
- RESET_PC, 0: PC value loaded on reset.
- PC_STEP, 1: sequential increment.

Ports:
- clk, input, 1: clock, rising edge.
- rst, input, 1: synchronous, active-high reset.
- en, input, 1: advance enable. When 0 in RUN, all state holds.
- branch_op, input, 3: 000 none, 001 BR, 010 BPL, 011 BMI, 100 BZ, 101 BNZ, 110/111 reserved.
- stack_op, input, 3: 000 none, 001 PUSH, 010 POP, 011 CALL, 100 RET, others none.
- target, input, ADDR_W: branch/call destination computed by the ALU.
- cond_val, input, DATA_W (signed): register value tested by conditional branches.
- mem_ret, input, ADDR_W: return address read from the memory stack.
- mem_ret_valid, input, 1: mem_ret is valid this cycle.
- pc_out, output, ADDR_W: current PC.
- taken, output, 1: one-cycle pulse; PC was redirected non-sequentially.
- busy, output, 1: high while in WAIT_RET.
- mem_ret_req, output, 1: high while in WAIT_RET; requests a memory-stack return address.
- ras_count, output, clog2(RAS_DEPTH)+1: number of valid RAS entries.
- ras_overflow, output, 1: sticky; set when a CALL overwrites the oldest entry.
- illegal_op, output, 1: one-cycle pulse on a reserved branch_op.

Behaviour:
- Reset (synchronous, priority over everything including WAIT_RET):
  - pc_out=RESET_PC, state=RUN, ras_count=0, RAS top pointer=0.
  - taken=0, busy=0, mem_ret_req=0, ras_overflow=0, illegal_op=0.
  - RAS contents are don't-care.
- State RUN, en=0: pc_out, RAS, ras_count and state hold; taken=0, illegal_op=0.
- State RUN, en=1, branch_op≠000 (stack_op ignored):
  - 001: pc←target, taken=1.
  - 010: if cond_val>0 then pc←target, taken=1; else pc←pc+PC_STEP.
  - 011: condition cond_val<0, otherwise as 010.
  - 100: condition cond_val==0, otherwise as 010.
  - 101: condition cond_val≠0, otherwise as 010.
  - 110/111: pc←pc+PC_STEP, illegal_op=1 for that cycle.
- State RUN, en=1, branch_op=000:
  - PUSH/POP/none/undefined stack_op: pc←pc+PC_STEP. The RAS is not touched; data-stack PUSH/POP are memory operations.
  - CALL: push (pc+PC_STEP) onto RAS, pc←target, taken=1.
    - Not full: ras_count+1.
    - Full: circular overwrite of the oldest entry; ras_count stays RAS_DEPTH; ras_overflow←1 (sticky until reset).
  - RET, ras_count>0: pc←RAS top, pop, ras_count−1, taken=1.
  - RET, ras_count==0: state←WAIT_RET, pc holds, taken=0.
- State WAIT_RET:
  - busy=1, mem_ret_req=1; en is ignored.
  - When mem_ret_valid=1: pc←mem_ret, taken=1, state←RUN, with busy and mem_ret_req low from the next cycle.
  - Otherwise pc holds indefinitely.
- Timing: all outputs are registered. pc_out and taken reflect the operation presented one clock earlier.
- Arithmetic: pc+PC_STEP is modulo 2^ADDR_W and wraps silently. The RAS pointer wraps modulo RAS_DEPTH.
- cond_val comparisons are signed two's complement.
- Overflowed entries are lost. After RAS_DEPTH+k CALLs, only the most recent RAS_DEPTH returns are served from the RAS; subsequent RETs take the WAIT_RET path.

Test Plan:
- Reset then 3 cycles en=1, ops 000 → pc_out 0,1,2,3; taken=0 throughout. Reset mid-stream → pc_out=RESET_PC next cycle.
- BPL with cond_val=−5 at pc=4, target=40 → pc=5, taken=0. BMI cond_val=−5 → pc=40, taken=1. BNZ cond_val=0 → pc+1. BZ cond_val=0 → target.
- RAS_DEPTH=8: CALL from pc=10 (target 100), then CALL from pc=100 (target 200), then RET, RET → pc 100,200,101,11; ras_count 1,2,1,0.
- 9 nested CALLs → ras_count=8, ras_overflow=1. Then 9 RETs: the first 8 return correctly; the 9th enters WAIT_RET.
- RET with empty RAS → busy=1, mem_ret_req=1, pc holds 3 cycles; mem_ret=0x55 with mem_ret_valid=1 → pc=0x55, taken=1, busy=0. Assert rst during WAIT_RET → RUN, pc=RESET_PC.
- en=0 with a CALL presented → no PC/RAS change. pc=0xFFFFFFFF sequential → pc=0. branch_op=111 → illegal_op pulse, pc+1.

Source files
------------

// File: rtl/pc_sequencer.sv
// Program-counter sequencer with hardware return-address stack.
// Falls back to a memory-stack return address when RET finds the RAS empty.
module pc_sequencer #(
    parameter int ADDR_W    = 32,
    parameter int DATA_W    = 32,
    parameter int RAS_DEPTH = 8,
    parameter logic [ADDR_W-1:0] RESET_PC = '0,
    parameter logic [ADDR_W-1:0] PC_STEP  = 1
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        en,
    input  logic [2:0]                  branch_op,
    input  logic [2:0]                  stack_op,
    input  logic [ADDR_W-1:0]           target,
    input  logic signed [DATA_W-1:0]    cond_val,
    input  logic [ADDR_W-1:0]           mem_ret,
    input  logic                        mem_ret_valid,
    output logic [ADDR_W-1:0]           pc_out,
    output logic                        taken,
    output logic                        busy,
    output logic                        mem_ret_req,
    output logic [$clog2(RAS_DEPTH):0]  ras_count,
    output logic                        ras_overflow,
    output logic                        illegal_op
);

    localparam int PTR_W = $clog2(RAS_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    localparam logic [2:0] BR_NONE = 3'b000;
    localparam logic [2:0] BR_BR   = 3'b001;
    localparam logic [2:0] BR_BPL  = 3'b010;
    localparam logic [2:0] BR_BMI  = 3'b011;
    localparam logic [2:0] BR_BZ   = 3'b100;
    localparam logic [2:0] BR_BNZ  = 3'b101;

    localparam logic [2:0] ST_CALL = 3'b011;
    localparam logic [2:0] ST_RET  = 3'b100;

    typedef enum logic {
        RUN,
        WAIT_RET
    } state_t;

    state_t              state;
    logic [ADDR_W-1:0]   ras [RAS_DEPTH];
    logic [PTR_W-1:0]    ptr;
    logic [PTR_W-1:0]    top_idx;
    logic [ADDR_W-1:0]   pc_seq;
    logic                cond_hit;
    logic                bad_br;
    logic                ras_full;
    logic                ras_empty;

    assign pc_seq    = pc_out + PC_STEP;
    assign top_idx   = ptr - 1'b1;
    assign ras_full  = (ras_count == CNT_W'(RAS_DEPTH));
    assign ras_empty = (ras_count == '0);

    always_comb begin
        cond_hit = 1'b0;
        bad_br   = 1'b0;
        case (branch_op)
            BR_BR:   cond_hit = 1'b1;
            BR_BPL:  cond_hit = (cond_val > 0);
            BR_BMI:  cond_hit = (cond_val < 0);
            BR_BZ:   cond_hit = (cond_val == 0);
            BR_BNZ:  cond_hit = (cond_val != 0);
            3'b110,
            3'b111:  bad_br   = 1'b1;
            default: ;
        endcase
    end

    // ptr names the next free slot; a full-stack CALL wraps onto the oldest entry.
    always_ff @(posedge clk) begin
        if (rst) begin
            pc_out       <= RESET_PC;
            state        <= RUN;
            ptr          <= '0;
            ras_count    <= '0;
            taken        <= 1'b0;
            busy         <= 1'b0;
            mem_ret_req  <= 1'b0;
            ras_overflow <= 1'b0;
            illegal_op   <= 1'b0;
        end else begin
            taken      <= 1'b0;
            illegal_op <= 1'b0;
            unique case (state)
                RUN: begin
                    if (en) begin
                        if (branch_op != BR_NONE) begin
                            if (bad_br) begin
                                pc_out     <= pc_seq;
                                illegal_op <= 1'b1;
                            end else if (cond_hit) begin
                                pc_out <= target;
                                taken  <= 1'b1;
                            end else begin
                                pc_out <= pc_seq;
                            end
                        end else if (stack_op == ST_CALL) begin
                            ras[ptr] <= pc_seq;
                            ptr      <= ptr + 1'b1;
                            pc_out   <= target;
                            taken    <= 1'b1;
                            if (ras_full)
                                ras_overflow <= 1'b1;
                            else
                                ras_count <= ras_count + 1'b1;
                        end else if (stack_op == ST_RET) begin
                            if (!ras_empty) begin
                                pc_out    <= ras[top_idx];
                                ptr       <= top_idx;
                                ras_count <= ras_count - 1'b1;
                                taken     <= 1'b1;
                            end else begin
                                state       <= WAIT_RET;
                                busy        <= 1'b1;
                                mem_ret_req <= 1'b1;
                            end
                        end else begin
                            pc_out <= pc_seq;
                        end
                    end
                end
                WAIT_RET: begin
                    if (mem_ret_valid) begin
                        pc_out      <= mem_ret;
                        taken       <= 1'b1;
                        state       <= RUN;
                        busy        <= 1'b0;
                        mem_ret_req <= 1'b0;
                    end
                end
                default: state <= RUN;
            endcase
        end
    end

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed vector bench for pc_sequencer (default parameters).
// Vectors are driven on the falling edge and checked 1 time unit after the rising edge.
module tb_pc_sequencer;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        en = 1'b0;
    logic [2:0]  branch_op = '0;
    logic [2:0]  stack_op = '0;
    logic [31:0] target = '0;
    logic signed [31:0] cond_val = '0;
    logic [31:0] mem_ret = '0;
    logic        mem_ret_valid = 1'b0;
    logic [31:0] pc_out;
    logic        taken;
    logic        busy;
    logic        mem_ret_req;
    logic [3:0]  ras_count;
    logic        ras_overflow;
    logic        illegal_op;

    int tests = 0;
    int fails = 0;

    pc_sequencer dut (
        .clk          (clk),
        .rst          (rst),
        .en           (en),
        .branch_op    (branch_op),
        .stack_op     (stack_op),
        .target       (target),
        .cond_val     (cond_val),
        .mem_ret      (mem_ret),
        .mem_ret_valid(mem_ret_valid),
        .pc_out       (pc_out),
        .taken        (taken),
        .busy         (busy),
        .mem_ret_req  (mem_ret_req),
        .ras_count    (ras_count),
        .ras_overflow (ras_overflow),
        .illegal_op   (illegal_op)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        rst;
        logic        en;
        logic [2:0]  br;
        logic [2:0]  st;
        logic [31:0] tgt;
        logic [31:0] cv;
        logic [31:0] mr;
        logic        mrv;
        logic [31:0] pc;
        logic        tk;
        logic        bz;
        logic        ill;
        logic        ovf;
        logic [3:0]  cnt;
    } vec_t;

    localparam logic [2:0] NONE = 3'd0, BR = 3'd1, BPL = 3'd2, BMI = 3'd3;
    localparam logic [2:0] BZ = 3'd4, BNZ = 3'd5, PUSH = 3'd1, POP = 3'd2;
    localparam logic [2:0] CALL = 3'd3, RET = 3'd4;

    function automatic vec_t v(
        input logic rs, input logic e, input logic [2:0] b, input logic [2:0] s,
        input logic [31:0] t, input logic [31:0] c, input logic [31:0] m,
        input logic mv, input logic [31:0] p, input logic k, input logic bz,
        input logic il, input logic ov, input logic [3:0] n);
        vec_t r;
        r.rst = rs; r.en = e; r.br = b; r.st = s; r.tgt = t; r.cv = c;
        r.mr = m; r.mrv = mv; r.pc = p; r.tk = k; r.bz = bz; r.ill = il;
        r.ovf = ov; r.cnt = n;
        return r;
    endfunction

    function automatic vec_t rstv();
        return v(1, 0, NONE, NONE, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    endfunction

    task automatic apply(input vec_t x, input string tag, input int idx);
        @(negedge clk);
        rst = x.rst; en = x.en; branch_op = x.br; stack_op = x.st;
        target = x.tgt; cond_val = x.cv; mem_ret = x.mr; mem_ret_valid = x.mrv;
        @(posedge clk);
        #1;
        tests++;
        if (pc_out !== x.pc || taken !== x.tk || busy !== x.bz ||
            mem_ret_req !== x.bz || illegal_op !== x.ill ||
            ras_overflow !== x.ovf || ras_count !== x.cnt) begin
            fails++;
            $display("FAIL %s[%0d] got pc=%h tk=%b bsy=%b req=%b ill=%b ovf=%b cnt=%0d want pc=%h tk=%b bsy=%b req=%b ill=%b ovf=%b cnt=%0d",
                     tag, idx, pc_out, taken, busy, mem_ret_req, illegal_op,
                     ras_overflow, ras_count, x.pc, x.tk, x.bz, x.bz, x.ill,
                     x.ovf, x.cnt);
        end
    endtask

    vec_t tbl[$];

    initial begin
        tbl.push_back(rstv());
        tbl.push_back(v(0, 1, NONE, NONE, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0));
        tbl.push_back(v(0, 1, NONE, NONE, 0, 0, 0, 0, 2, 0, 0, 0, 0, 0));
        tbl.push_back(v(0, 1, NONE, NONE, 0, 0, 0, 0, 3, 0, 0, 0, 0, 0));
        tbl.push_back(rstv());
        for (int i = 1; i <= 4; i++)
            tbl.push_back(v(0, 1, NONE, NONE, 0, 0, 0, 0, i, 0, 0, 0, 0, 0));
        tbl.push_back(v(0, 1, BPL, NONE, 40, -5, 0, 0, 5, 0, 0, 0, 0, 0));
        tbl.push_back(v(0, 1, BMI, NONE, 40, -5, 0, 0, 40, 1, 0, 0, 0, 0));
        tbl.push_back(v(0, 1, BNZ, NONE, 80, 0, 0, 0, 41, 0, 0, 0, 0, 0));
        tbl.push_back(v(0, 1, BZ, NONE, 80, 0, 0, 0, 80, 1, 0, 0, 0, 0));
        tbl.push_back(v(0, 1, BMI, NONE, 90, 3, 0, 0, 81, 0, 0, 0, 0, 0));
        tbl.push_back(v(0, 1, BPL, NONE, 10, 7, 0, 0, 10, 1, 0, 0, 0, 0));
        tbl.push_back(v(0, 1, NONE, CALL, 100, 0, 0, 0, 100, 1, 0, 0, 0, 1));
        tbl.push_back(v(0, 1, NONE, CALL, 200, 0, 0, 0, 200, 1, 0, 0, 0, 2));
        tbl.push_back(v(0, 1, NONE, RET, 0, 0, 0, 0, 101, 1, 0, 0, 0, 1));
        tbl.push_back(v(0, 1, NONE, RET, 0, 0, 0, 0, 11, 1, 0, 0, 0, 0));
        tbl.push_back(v(0, 0, NONE, CALL, 500, 0, 0, 0, 11, 0, 0, 0, 0, 0));
        tbl.push_back(v(0, 1, NONE, PUSH, 500, 0, 0, 0, 12, 0, 0, 0, 0, 0));
        tbl.push_back(v(0, 1, NONE, POP, 500, 0, 0, 0, 13, 0, 0, 0, 0, 0));
        tbl.push_back(v(0, 1, 3'b111, NONE, 500, 0, 0, 0, 14, 0, 0, 1, 0, 0));
        tbl.push_back(v(0, 1, 3'b110, CALL, 500, 0, 0, 0, 15, 0, 0, 1, 0, 0));
        tbl.push_back(v(0, 1, BR, CALL, 30, 0, 0, 0, 30, 1, 0, 0, 0, 0));
        tbl.push_back(v(0, 1, NONE, RET, 0, 0, 0, 0, 30, 0, 1, 0, 0, 0));
        for (int i = 0; i < 3; i++)
            tbl.push_back(v(0, 1, BR, CALL, 700, 0, 'h99, 0, 30, 0, 1, 0, 0, 0));
        tbl.push_back(v(0, 0, NONE, NONE, 0, 0, 'h55, 1, 'h55, 1, 0, 0, 0, 0));
        tbl.push_back(v(0, 1, NONE, NONE, 0, 0, 0, 0, 'h56, 0, 0, 0, 0, 0));
        tbl.push_back(v(0, 1, NONE, RET, 0, 0, 0, 0, 'h56, 0, 1, 0, 0, 0));
        tbl.push_back(rstv());
        tbl.push_back(v(0, 1, BR, NONE, 32'hFFFF_FFFF, 0, 0, 0, 32'hFFFF_FFFF, 1, 0, 0, 0, 0));
        tbl.push_back(v(0, 1, NONE, NONE, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));

        for (int i = 0; i < tbl.size(); i++)
            apply(tbl[i], "vec", i);

        // RAS overflow: 9 nested calls, then 9 returns
        apply(rstv(), "ovf_rst", 0);
        for (int k = 1; k <= 9; k++)
            apply(v(0, 1, NONE, CALL, 32'(k * 'h100), 0, 0, 0, 32'(k * 'h100),
                    1, 0, 0, k > 8, 4'((k > 8) ? 8 : k)), "call", k);
        for (int j = 1; j <= 8; j++)
            apply(v(0, 1, NONE, RET, 0, 0, 0, 0, 32'((9 - j) * 'h100 + 1),
                    1, 0, 0, 1, 4'(8 - j)), "ret", j);
        apply(v(0, 1, NONE, RET, 0, 0, 0, 0, 'h101, 0, 1, 0, 1, 0), "ret", 9);
        apply(v(0, 1, NONE, NONE, 0, 0, 'h77, 1, 'h77, 1, 0, 0, 1, 0), "memret", 0);
        apply(v(0, 1, NONE, RET, 0, 0, 0, 0, 'h77, 0, 1, 0, 1, 0), "wait2", 0);
        apply(rstv(), "rst_in_wait", 0);
        apply(v(0, 1, NONE, NONE, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0), "after_rst", 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
